// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 8x8 MAC datapath. Accepts a start command with a pair
// count, clears the MAC accumulator, streams the operand pairs into the MAC,
// waits for every issued op to retire, then returns the dot product as two
// bytes (MSB first) over a valid/ready handshake.
module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic              mac_valid,
  input  logic [ACC_W-1:0]  mac_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_byte,
  output logic              res_last
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT_HI = 3'd4,
    S_OUT_LO = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]   mac_a_q, mac_b_q;
  logic                mac_en_q;
  logic                accept;
  logic                retire;

  assign mac_en = mac_en_q;
  assign mac_a  = mac_a_q;
  assign mac_b  = mac_b_q;

  // Next-state, handshake and output decode for the job sequence.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    accept      = 1'b0;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    op_ready    = 1'b0;
    mac_clr     = 1'b0;
    res_valid   = 1'b0;
    res_byte    = '0;
    res_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = len;
          if (len == '0) begin
            // Empty job: the answer is zero and the MAC is left untouched.
            result_d = '0;
            state_d  = S_OUT_HI;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        mac_clr = 1'b1;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept      = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last issue strobe must have been counted and every op retired.
        if ((pending_q == '0) && !mac_en_q) begin
          result_d = mac_c;
          state_d  = S_OUT_HI;
        end
      end
      S_OUT_HI: begin
        res_valid = 1'b1;
        res_byte  = result_q[ACC_W-1 -: DATA_W];
        if (res_ready) state_d = S_OUT_LO;
      end
      S_OUT_LO: begin
        res_valid = 1'b1;
        res_byte  = result_q[DATA_W-1:0];
        res_last  = 1'b1;
        if (res_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight op count: +1 per issue strobe, -1 per retire; stray retires ignored.
  always_comb begin
    pending_d = pending_q;
    retire    = mac_valid && (pending_q != '0);
    case ({mac_en_q, retire})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      pending_q   <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      result_q    <= result_d;
    end
  end

  // Operand registers and the one-cycle issue strobe toward the MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_en_q <= 1'b0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
    end else begin
      mac_en_q <= accept;
      if (accept) begin
        mac_a_q <= op_a;
        mac_b_q <= op_b;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a small MAC model closes the loop, a stimulus thread
// runs jobs and queues the expected result bytes, and a monitor pops and
// compares each byte the controller hands over.
module tb_mac_seq_ctrl;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;
  localparam int PEND_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DATA_W-1:0] op_a = '0, op_b = '0;
  logic              mac_clr, mac_en;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic              mac_valid;
  logic [ACC_W-1:0]  mac_c;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [DATA_W-1:0] res_byte;
  logic              res_last;

  mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(mac_valid), .mac_c(mac_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_byte(res_byte), .res_last(res_last)
  );

  always #5 clk = ~clk;

  // Two-stage MAC model: product retires two cycles after the issue strobe.
  logic              p_vld0 = 1'b0, p_vld1 = 1'b0;
  logic [ACC_W-1:0]  p_prod0 = '0, p_prod1 = '0;
  logic [ACC_W-1:0]  acc = '0;
  always @(posedge clk) begin
    p_vld0  <= mac_en;
    p_prod0 <= ACC_W'(mac_a) * ACC_W'(mac_b);
    p_vld1  <= p_vld0;
    p_prod1 <= p_prod0;
    if (mac_clr)     acc <= '0;
    else if (p_vld1) acc <= acc + p_prod1;
  end
  assign mac_valid = p_vld1;
  assign mac_c     = acc;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    tot_cnt++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Expected result bytes: {last, byte}.
  logic [8:0] exp_q[$];
  int qa[$];
  int qb[$];

  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_byte = '0;
  logic prev_last = 1'b0;

  // Monitor: compare each accepted byte, check stability while stalled, count strobes.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && res_valid) begin
        check("stall_byte", 32'(res_byte), 32'(prev_byte));
        check("stall_last", 32'(res_last), 32'(prev_last));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_res_byte");
        end else begin
          check("res_byte", 32'(res_byte), 32'(exp_q[0][7:0]));
          check("res_last", 32'(res_last), 32'(exp_q[0][8]));
          void'(exp_q.pop_front());
        end
      end
      prev_stall <= res_valid && !res_ready;
      prev_byte  <= res_byte;
      prev_last  <= res_last;
      en_cnt     <= en_cnt + int'(mac_en);
      clr_cnt    <= clr_cnt + int'(mac_clr);
      done_cnt   <= done_cnt + int'(done);
      busy_cnt   <= busy_cnt + int'(busy);
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (busy) fail_now("wait_idle");
  endtask

  // One complete job: operands come from qa/qb if preloaded, else random.
  task automatic run_job(input int n, input bit rnd, input int stall, input bit spam);
    int en0, clr0, done0, busy0, sent, g, sum;
    bit got;
    logic [ACC_W-1:0] expv;
    wait_idle();
    if (qa.size() != n) begin
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 255)));
        qb.push_back(int'($urandom_range(0, 255)));
      end
    end
    sum = 0;
    for (int i = 0; i < n; i++) sum += qa[i] * qb[i];
    expv = sum[ACC_W-1:0];
    exp_q.push_back({1'b0, expv[15:8]});
    exp_q.push_back({1'b1, expv[7:0]});
    res_ready = (stall == 0);
    @(posedge clk); #1;
    en0 = en_cnt; clr0 = clr_cnt; done0 = done_cnt; busy0 = busy_cnt;
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = spam;
    sent = 0; g = 0;
    while (sent < n && g < 1000) begin
      op_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      op_a = DATA_W'(qa[sent]);
      op_b = DATA_W'(qb[sent]);
      @(negedge clk);
      if (op_valid && op_ready) sent++;
      @(posedge clk); #1;
      g++;
    end
    op_valid = 1'b0;
    if (sent < n) fail_now("op_stream");
    if (stall != 0) begin
      g = 0;
      while (!res_valid && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (!res_valid) fail_now("res_valid_wait");
      repeat (stall) begin
        @(posedge clk); #1;
      end
      res_ready = 1'b1;
    end
    got = 1'b0; g = 0;
    while (!got && g < 300) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    start = 1'b0;
    if (!got) fail_now("done_wait");
    check("mac_en_count", 32'(en_cnt - en0), 32'(n));
    check("mac_clr_count", 32'(clr_cnt - clr0), (n != 0) ? 32'd1 : 32'd0);
    check("done_count", 32'(done_cnt - done0), 32'd1);
    if (n == 0) check("busy_cycles_len0", 32'(busy_cnt - busy0), 32'd2);
    if (spam) begin
      @(negedge clk);
      check("idle_after_spam", 32'(busy), 32'd0);
    end
    qa.delete(); qb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_op_ready"},  32'(op_ready), 32'd0);
    check({tag, "_mac_en"},    32'(mac_en), 32'd0);
    check({tag, "_mac_clr"},   32'(mac_clr), 32'd0);
    check({tag, "_mac_ab"},    32'({mac_a, mac_b}), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_out"},   32'({res_byte, res_last}), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
  endtask

  initial begin
    int sent, g;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Known pairs, back-to-back.
    qa = '{2, 4, 1}; qb = '{3, 5, 1};
    run_job(3, 1'b0, 0, 1'b0);
    // Empty job.
    run_job(0, 1'b0, 0, 1'b0);
    // Wrap modulo 2**16.
    qa = '{255, 255}; qb = '{255, 255};
    run_job(2, 1'b0, 0, 1'b0);
    // Bursty operands and a stalled consumer.
    run_job(4, 1'b1, 5, 1'b0);

    // Reset in the middle of ACCUM after two of four pairs.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; g = 0;
    while (sent < 2 && g < 100) begin
      op_valid = 1'b1;
      op_a = DATA_W'(9); op_b = DATA_W'(9);
      @(negedge clk);
      if (op_ready) sent++;
      @(posedge clk); #1;
      g++;
    end
    op_valid = 1'b0;
    if (sent < 2) fail_now("reset_job_stream");
    reset = 1'b1;
    #1;
    check_all_zero("midjob_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    qa = '{7}; qb = '{6};
    run_job(1, 1'b0, 0, 1'b0);

    // Start held high through ACCUM and OUT_LO must not spawn extra jobs.
    run_job(3, 1'b1, 0, 1'b1);

    // A few random jobs.
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
